usb_tx_serializer: RTL and testbench

USB_TX_SERIALIZER -- requirements
Module: usb_tx_serializer

---
 rtl/usb_tx_serializer.sv | 149 ++++++++++++++
 tb/tb_usb_tx_serializer.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/usb_tx_serializer.sv
// USB low-level transmitter: byte stream -> NRZI + bit-stuffed D+/D- with SE0/J end-of-packet.
// First bit 1 clk after acceptance, 8 clk per symbol; byte_ready is a sample strobe and byte_valid=0 on it aborts.
module usb_tx_serializer (
    input  logic       clk,
    input  logic       n_rst,
    input  logic [7:0] tx_byte,
    input  logic       byte_valid,
    input  logic       tx_last,
    output logic       byte_ready,
    output logic       dplus_out,
    output logic       dminus_out,
    output logic       tx_active,
    output logic       tx_done,
    output logic       tx_error
);

    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] SEND    = 3'd1;
    localparam logic [2:0] STUFF   = 3'd2;
    localparam logic [2:0] EOP_SE0 = 3'd3;
    localparam logic [2:0] EOP_J   = 3'd4;

    localparam logic [3:0] SYM_LAST = 4'd7;
    localparam logic [3:0] SE0_LAST = 4'd15;

    logic [2:0] state,     state_nxt;
    logic [3:0] bit_tmr,   bit_tmr_nxt;
    logic [2:0] bit_idx,   bit_idx_nxt;
    logic [2:0] ones_cnt,  ones_cnt_nxt;
    logic [6:0] shreg,     shreg_nxt;
    logic       last_byte, last_byte_nxt;
    logic       line_j,    line_j_nxt;

    logic on_bit;
    logic bit_end;
    logic stuff_due;
    logic boundary;
    logic idle_accept;

    assign on_bit      = (state == SEND) || (state == STUFF);
    assign bit_end     = on_bit && (bit_tmr == SYM_LAST);
    assign stuff_due   = (state == SEND) && (ones_cnt == 3'd6);
    assign boundary    = bit_end && !stuff_due && (bit_idx == 3'd7) && !last_byte;
    assign idle_accept = (state == IDLE) && byte_valid;

    // Strobes gated by n_rst so nothing leaks out while reset is held
    assign byte_ready = n_rst && (idle_accept || boundary);
    assign tx_error   = n_rst && boundary && !byte_valid;
    assign tx_done    = n_rst && (state == EOP_J) && (bit_tmr == SYM_LAST);
    assign tx_active  = (state != IDLE);

    assign dplus_out  = on_bit ? line_j  : (state != EOP_SE0);
    assign dminus_out = on_bit ? ~line_j : 1'b0;

    always_comb begin
        state_nxt     = state;
        bit_tmr_nxt   = bit_tmr + 4'd1;
        bit_idx_nxt   = bit_idx;
        ones_cnt_nxt  = ones_cnt;
        shreg_nxt     = shreg;
        last_byte_nxt = last_byte;
        line_j_nxt    = line_j;

        case (state)
            IDLE: begin
                bit_tmr_nxt = 4'd0;
                line_j_nxt  = 1'b1;
                if (byte_valid) begin
                    state_nxt     = SEND;
                    shreg_nxt     = tx_byte[7:1];
                    last_byte_nxt = tx_last;
                    bit_idx_nxt   = 3'd0;
                    // First symbol is referenced to the idle J level
                    line_j_nxt    = tx_byte[0];
                    ones_cnt_nxt  = tx_byte[0] ? 3'd1 : 3'd0;
                end
            end

            SEND, STUFF: begin
                if (bit_end) begin
                    bit_tmr_nxt = 4'd0;
                    if (stuff_due) begin
                        state_nxt    = STUFF;
                        line_j_nxt   = ~line_j;
                        ones_cnt_nxt = 3'd0;
                    end else if (bit_idx != 3'd7) begin
                        state_nxt    = SEND;
                        bit_idx_nxt  = bit_idx + 3'd1;
                        shreg_nxt    = {1'b0, shreg[6:1]};
                        line_j_nxt   = shreg[0] ? line_j : ~line_j;
                        ones_cnt_nxt = shreg[0] ? ones_cnt + 3'd1 : 3'd0;
                    end else if (!last_byte && byte_valid) begin
                        // Next byte continues the NRZI level and ones run seamlessly
                        state_nxt     = SEND;
                        bit_idx_nxt   = 3'd0;
                        shreg_nxt     = tx_byte[7:1];
                        last_byte_nxt = tx_last;
                        line_j_nxt    = tx_byte[0] ? line_j : ~line_j;
                        ones_cnt_nxt  = tx_byte[0] ? ones_cnt + 3'd1 : 3'd0;
                    end else begin
                        state_nxt = EOP_SE0;
                    end
                end
            end

            EOP_SE0: begin
                if (bit_tmr == SE0_LAST) begin
                    state_nxt   = EOP_J;
                    bit_tmr_nxt = 4'd0;
                end
            end

            EOP_J: begin
                if (bit_tmr == SYM_LAST) begin
                    state_nxt   = IDLE;
                    bit_tmr_nxt = 4'd0;
                    line_j_nxt  = 1'b1;
                end
            end

            default: begin
                state_nxt   = IDLE;
                bit_tmr_nxt = 4'd0;
                line_j_nxt  = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state     <= IDLE;
            bit_tmr   <= 4'd0;
            bit_idx   <= 3'd0;
            ones_cnt  <= 3'd0;
            shreg     <= 7'd0;
            last_byte <= 1'b0;
            line_j    <= 1'b1;
        end else begin
            state     <= state_nxt;
            bit_tmr   <= bit_tmr_nxt;
            bit_idx   <= bit_idx_nxt;
            ones_cnt  <= ones_cnt_nxt;
            shreg     <= shreg_nxt;
            last_byte <= last_byte_nxt;
            line_j    <= line_j_nxt;
        end
    end

endmodule

// File: tb/tb_usb_tx_serializer.sv
// Bench for usb_tx_serializer: per-cycle compare against a symbol-level packet model plus literal timing pins.
module tb_usb_tx_serializer;

    localparam int MAXC = 40000;
    // Output vector layout: {dplus, dminus, active, ready, done, error}
    localparam logic [5:0] QUIET = 6'b100000;

    logic       clk = 1'b0;
    logic       n_rst;
    logic [7:0] tx_byte;
    logic       byte_valid;
    logic       tx_last;
    logic       byte_ready;
    logic       dplus_out;
    logic       dminus_out;
    logic       tx_active;
    logic       tx_done;
    logic       tx_error;

    usb_tx_serializer dut (
        .clk        (clk),
        .n_rst      (n_rst),
        .tx_byte    (tx_byte),
        .byte_valid (byte_valid),
        .tx_last    (tx_last),
        .byte_ready (byte_ready),
        .dplus_out  (dplus_out),
        .dminus_out (dminus_out),
        .tx_active  (tx_active),
        .tx_done    (tx_done),
        .tx_error   (tx_error)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [5:0] exp_out [MAXC];
    logic [5:0] obs_out [MAXC];
    bit         chk     [MAXC];
    bit         drv_spec[MAXC];
    logic       drv_v   [MAXC];
    logic [7:0] drv_b   [MAXC];
    logic       drv_l   [MAXC];

    int total = 0;
    int bad   = 0;

    logic [7:0] pkt [$];

    always @(negedge clk) begin
        if (cyc < MAXC) begin
            obs_out[cyc] = {dplus_out, dminus_out, tx_active, byte_ready, tx_done, tx_error};
            if (chk[cyc]) begin
                total++;
                if (obs_out[cyc] !== exp_out[cyc]) begin
                    bad++;
                    $display("FAIL lines_flags cycle %0d {dp,dm,act,rdy,done,err}: got %b want %b",
                             cyc, obs_out[cyc], exp_out[cyc]);
                end
            end
        end
    end

    function automatic void put(input int c, input logic [5:0] v);
        if (c < MAXC) begin
            exp_out[c] = v;
            chk[c]     = 1'b1;
        end
    endfunction

    function automatic void emit(input int c, input logic lvl);
        for (int q = 0; q < 8; q++) put(c + q, {lvl, ~lvl, 4'b1000});
    endfunction

    function automatic int find_bit(input int from, input int to, input int pos);
        for (int c = from; c <= to && c < MAXC; c++)
            if (obs_out[c][pos] === 1'b1) return c - from;
        return -1;
    endfunction

    task automatic check_lit(input string name, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, got, want);
        end
    endtask

    task automatic idle(input int g);
        for (int i = 0; i < g; i++) begin
            put(cyc, QUIET);
            byte_valid = 1'b0;
            tx_byte    = 8'($urandom);
            tx_last    = 1'($urandom);
            @(posedge clk); #1;
        end
    endtask

    // Model: NRZI from J, stuff after six 1s (run carries across bytes), then SE0 x16 and J x8.
    task automatic send_packet(input bit underrun, input int abort_at, output int base, output int len);
        int n, j, ones;
        logic lvl;
        logic [7:0] cur;
        n    = pkt.size();
        base = cyc;
        for (int c = base; c < base + 1000 && c < MAXC; c++) drv_spec[c] = 1'b0;

        put(base, 6'b100100);
        drv_spec[base] = 1'b1;
        drv_v[base]    = 1'b1;
        drv_b[base]    = pkt[0];
        drv_l[base]    = (n == 1) && !underrun;

        lvl = 1'b1; ones = 0; j = 1;
        for (int i = 0; i < n; i++) begin
            cur = pkt[i];
            for (int k = 0; k < 8; k++) begin
                if (cur[k]) ones++;
                else begin lvl = ~lvl; ones = 0; end
                emit(base + j, lvl); j += 8;
                if (ones == 6) begin
                    lvl = ~lvl; ones = 0;
                    emit(base + j, lvl); j += 8;
                end
            end
            if (i < n - 1) begin
                put(base + j - 1, {lvl, ~lvl, 4'b1100});
                drv_spec[base + j - 1] = 1'b1;
                drv_v[base + j - 1]    = 1'b1;
                drv_b[base + j - 1]    = pkt[i + 1];
                drv_l[base + j - 1]    = (i + 1 == n - 1) && !underrun;
            end else if (underrun) begin
                put(base + j - 1, {lvl, ~lvl, 4'b1101});
                drv_spec[base + j - 1] = 1'b1;
                drv_v[base + j - 1]    = 1'b0;
                drv_b[base + j - 1]    = 8'($urandom);
                drv_l[base + j - 1]    = 1'($urandom);
            end
        end
        for (int k = 0; k < 16; k++) put(base + j + k, 6'b001000);
        j += 16;
        for (int k = 0; k < 8; k++) put(base + j + k, (k == 7) ? 6'b101010 : 6'b101000);
        j += 8;
        len = j;

        for (int t = 0; t < len; t++) begin
            if (abort_at > 0 && t == abort_at) begin
                n_rst = 1'b0;
                for (int r = 0; r < 3; r++) begin
                    put(cyc, QUIET);
                    byte_valid = 1'b1;
                    tx_byte    = 8'($urandom);
                    tx_last    = 1'($urandom);
                    @(posedge clk); #1;
                end
                n_rst = 1'b1;
                return;
            end
            if (drv_spec[base + t]) begin
                byte_valid = drv_v[base + t];
                tx_byte    = drv_b[base + t];
                tx_last    = drv_l[base + t];
            end else begin
                byte_valid = 1'($urandom);
                tx_byte    = 8'($urandom);
                tx_last    = 1'($urandom);
            end
            @(posedge clk); #1;
        end
    endtask

    initial begin
        int b, b2, len, pat, cnt, n;
        logic [7:0] pb;

        n_rst = 1'b0; byte_valid = 1'b1; tx_byte = 8'hA5; tx_last = 1'b1;
        @(posedge clk); #1;
        for (int r = 0; r < 3; r++) begin
            put(cyc, QUIET);
            @(posedge clk); #1;
        end
        n_rst = 1'b1;

        // Single 0x80, accepted on the first cycle out of reset
        pkt = {8'h80};
        send_packet(0, 0, b, len);
        check_lit("model_len_0x80", len, 89);
        pat = 0;
        for (int k = 0; k < 8; k++) pat |= int'(obs_out[b + 1 + 8 * k + 4][5]) << k;
        check_lit("lines_KJKJKJKK", pat, 8'b00101010);
        check_lit("done_offset_0x80", find_bit(b, b + 120, 1), 88);
        cnt = 0;
        for (int c = b; c < b + 100; c++) cnt += int'(obs_out[c][3]);
        check_lit("active_clks_0x80", cnt, 88);
        idle(2);

        pkt = {8'hFF, 8'h00};
        send_packet(0, 0, b, len);
        check_lit("second_ready_FF_00", find_bit(b + 1, b + 200, 2) + 1, 72);
        idle(1);

        pkt = {8'hFC};
        send_packet(0, 0, b, len);
        check_lit("stuff_K_before_eop", int'(obs_out[b + 72][5:4]), 2'b01);
        check_lit("se0_start_FC", int'(obs_out[b + 73][5:4]), 2'b00);
        idle(3);

        pkt = {8'h01};
        send_packet(1, 0, b, len);
        check_lit("underrun_err_offset", find_bit(b, b + 120, 0), 64);
        check_lit("underrun_done_offset", find_bit(b, b + 120, 1), 88);
        idle(1);

        pkt = {8'hFC, 8'h00};
        send_packet(0, 0, b, len);
        check_lit("ready_after_boundary_stuff", find_bit(b + 1, b + 200, 2) + 1, 72);
        idle(2);

        // Reset during bit 3 of 0xFF leaves a run of four 1s that must not survive
        pkt = {8'hFF, 8'h00};
        send_packet(0, 28, b, len);
        pkt = {8'h03};
        send_packet(0, 0, b2, len);
        check_lit("post_reset_first_J", int'(obs_out[b2 + 1][5]), 1);
        check_lit("post_reset_no_stuff", find_bit(b2, b2 + 120, 1), 88);

        // Back-to-back: next accept in the cycle following tx_done
        pkt = {8'h80};
        send_packet(0, 0, b, len);
        pkt = {8'h81};
        send_packet(0, 0, b2, len);
        check_lit("b2b_accept_gap", find_bit(b + 1, b + 200, 2) + 1, 89);
        check_lit("b2b_first_bit_J", int'(obs_out[b2 + 1][5]), 1);

        for (int p = 0; p < 30; p++) begin
            pkt.delete();
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++) begin
                pb = ($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom);
                pkt.push_back(pb);
            end
            send_packet($urandom_range(0, 7) == 0, 0, b, len);
            idle($urandom_range(0, 3));
        end

        idle(4);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
